// File: rtl/axi_mport_pkg.sv
// rtl/axi_mport_pkg.sv - shared state type, AXI constants and round-robin picker for axi_mport_ctl
package axi_mport_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int MAX_PORTS = 8;

    // First set request at or above ptr, wrapping at n; the lowest offset wins.
    function automatic logic [MAX_PORTS-1:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                                     input logic [2:0] ptr,
                                                     input int n);
        logic [MAX_PORTS-1:0] pick;
        logic [2:0] idx;
        pick = '0;
        for (int i = MAX_PORTS - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = 3'((int'(ptr) + i) % n);
                if (req[idx]) begin
                    pick      = '0;
                    pick[idx] = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axi_mport_linebuf.sv
// rtl/axi_mport_linebuf.sv - line buffer, one write port and two asynchronous read ports
module axi_mport_linebuf #(
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 8,
    parameter int IDX_W     = $clog2(MAX_BEATS)
) (
    input  logic              clk,
    input  logic              wen,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [IDX_W-1:0]  ridx_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [MAX_BEATS];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata_a = mem[ridx_a];
    assign rdata_b = mem[ridx_b];

endmodule

// File: rtl/axi_mport_ctl.sv
// rtl/axi_mport_ctl.sv - N-port round-robin AXI4 master with a shared line buffer
module axi_mport_ctl
    import axi_mport_pkg::*;
#(
    parameter int N_PORTS   = 2,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4,
    parameter int MAX_BEATS = 8,
    parameter int IDX_W     = $clog2(MAX_BEATS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_PORTS-1:0]             req,
    input  logic [N_PORTS-1:0]             we,
    input  logic [N_PORTS*ADDR_W-1:0]      addr,
    input  logic [N_PORTS*8-1:0]           len,
    input  logic [N_PORTS*(DATA_W/8)-1:0]  strb,
    input  logic [N_PORTS-1:0]             commit,
    input  logic [N_PORTS-1:0]             ack,
    output logic [N_PORTS-1:0]             grant,
    output logic [N_PORTS-1:0]             done,
    output logic                           err,
    input  logic                           buf_wen,
    input  logic [IDX_W-1:0]               buf_idx,
    input  logic [DATA_W-1:0]              buf_wdata,
    output logic [DATA_W-1:0]              buf_rdata,
    output logic                           ar_valid,
    input  logic                           ar_ready,
    output logic [ADDR_W-1:0]              ar_addr,
    output logic [ID_W-1:0]                ar_id,
    output logic [7:0]                     ar_len,
    output logic [2:0]                     ar_size,
    output logic [1:0]                     ar_burst,
    input  logic                           r_valid,
    output logic                           r_ready,
    input  logic [DATA_W-1:0]              r_data,
    input  logic [1:0]                     r_resp,
    input  logic                           r_last,
    output logic                           aw_valid,
    input  logic                           aw_ready,
    output logic [ADDR_W-1:0]              aw_addr,
    output logic [ID_W-1:0]                aw_id,
    output logic [7:0]                     aw_len,
    output logic [2:0]                     aw_size,
    output logic [1:0]                     aw_burst,
    output logic                           w_valid,
    input  logic                           w_ready,
    output logic [DATA_W-1:0]              w_data,
    output logic [DATA_W/8-1:0]            w_strb,
    output logic                           w_last,
    input  logic                           b_valid,
    output logic                           b_ready,
    input  logic [1:0]                     b_resp
);

    localparam logic [IDX_W:0] BEAT_ONE = 1;

    state_t                 state, state_nxt;
    logic [2:0]             rr_ptr, gidx, pick_idx;
    logic [MAX_PORTS-1:0]   req_ext, pick;
    logic [ADDR_W-1:0]      addr_sel, lat_addr;
    logic [7:0]             len_sel;
    logic [IDX_W-1:0]       len_clamped, lat_len;
    logic [DATA_W/8-1:0]    strb_sel, lat_strb;
    logic                   we_sel;
    logic [IDX_W:0]         beat;
    logic                   beat_in_range, last_beat;
    logic                   lb_wen;
    logic [IDX_W-1:0]       lb_widx;
    logic [DATA_W-1:0]      lb_wdata;
    logic                   unused_resp_bits;

    assign unused_resp_bits = ^{r_resp[0], b_resp[0]};

    always_comb begin
        req_ext                = '0;
        req_ext[N_PORTS-1:0]   = req;
    end

    assign pick = rr_pick(req_ext, rr_ptr, N_PORTS);

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (pick[i]) pick_idx = 3'(i);
        end
    end

    assign addr_sel    = addr[int'(pick_idx)*ADDR_W +: ADDR_W];
    assign len_sel     = len[int'(pick_idx)*8 +: 8];
    assign strb_sel    = strb[int'(pick_idx)*(DATA_W/8) +: DATA_W/8];
    assign we_sel      = |(we & pick[N_PORTS-1:0]);
    assign len_clamped = (int'(len_sel) >= MAX_BEATS) ? IDX_W'(MAX_BEATS - 1) : len_sel[IDX_W-1:0];

    // beat saturates at len+1 so surplus read beats can never wrap onto earlier slots
    assign beat_in_range = (beat <= {1'b0, lat_len});
    assign last_beat     = (beat == {1'b0, lat_len});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        b_ready   = 1'b0;
        done      = '0;
        case (state)
            ST_IDLE: if (|req) state_nxt = we_sel ? ST_LOAD : ST_AR;
            ST_LOAD: if (|(commit & grant)) state_nxt = ST_AW;
            ST_AR: begin
                ar_valid = 1'b1;
                if (ar_ready) state_nxt = ST_R;
            end
            ST_R: begin
                r_ready = 1'b1;
                if (r_valid && r_last) state_nxt = ST_DONE;
            end
            ST_AW: begin
                aw_valid = 1'b1;
                if (aw_ready) state_nxt = ST_W;
            end
            ST_W: begin
                w_valid = 1'b1;
                if (w_ready && last_beat) state_nxt = ST_B;
            end
            ST_B: begin
                b_ready = 1'b1;
                if (b_valid) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = grant;
                if (|(ack & grant)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= '0;
            gidx     <= '0;
            grant    <= '0;
            err      <= 1'b0;
            beat     <= '0;
            lat_addr <= '0;
            lat_len  <= '0;
            lat_strb <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        grant    <= pick[N_PORTS-1:0];
                        gidx     <= pick_idx;
                        lat_addr <= addr_sel;
                        lat_len  <= len_clamped;
                        lat_strb <= strb_sel;
                        beat     <= '0;
                        err      <= 1'b0;
                    end
                end
                ST_R: begin
                    if (r_valid) begin
                        err <= err | r_resp[1];
                        if (beat_in_range) beat <= beat + BEAT_ONE;
                    end
                end
                ST_W: if (w_ready && !last_beat) beat <= beat + BEAT_ONE;
                ST_B: if (b_valid) err <= b_resp[1];
                ST_DONE: begin
                    if (|(ack & grant)) begin
                        grant  <= '0;
                        err    <= 1'b0;
                        rr_ptr <= (gidx == 3'(N_PORTS - 1)) ? 3'd0 : gidx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // AXI R owns the buffer write port while reading; the granted port only during LOAD
    assign lb_wen   = (state == ST_LOAD && buf_wen) || (state == ST_R && r_valid && beat_in_range);
    assign lb_widx  = (state == ST_R) ? beat[IDX_W-1:0] : buf_idx;
    assign lb_wdata = (state == ST_R) ? r_data : buf_wdata;

    axi_mport_linebuf #(
        .DATA_W    (DATA_W),
        .MAX_BEATS (MAX_BEATS),
        .IDX_W     (IDX_W)
    ) u_linebuf (
        .clk     (clk),
        .wen     (lb_wen),
        .widx    (lb_widx),
        .wdata   (lb_wdata),
        .ridx_a  (beat[IDX_W-1:0]),
        .rdata_a (w_data),
        .ridx_b  (buf_idx),
        .rdata_b (buf_rdata)
    );

    assign ar_addr  = lat_addr;
    assign aw_addr  = lat_addr;
    assign ar_id    = ID_W'(gidx);
    assign aw_id    = ID_W'(gidx);
    assign ar_len   = 8'(lat_len);
    assign aw_len   = 8'(lat_len);
    assign ar_size  = 3'($clog2(DATA_W / 8));
    assign aw_size  = 3'($clog2(DATA_W / 8));
    assign ar_burst = AXI_BURST_INCR;
    assign aw_burst = AXI_BURST_INCR;
    assign w_strb   = lat_strb;
    assign w_last   = last_beat;

endmodule

// File: tb/tb_axi_mport_ctl.sv
// tb/tb_axi_mport_ctl.sv - self-checking bench for axi_mport_ctl with a three-port configuration
module tb_axi_mport_ctl;

    localparam int NP = 3;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int MB = 8;
    localparam int XW = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NP-1:0]     req, we, commit, ack, grant, done;
    logic [NP*AW-1:0]  addr;
    logic [NP*8-1:0]   len;
    logic [NP*8-1:0]   strb;
    logic              err, buf_wen;
    logic [XW-1:0]     buf_idx;
    logic [DW-1:0]     buf_wdata, buf_rdata;
    logic              ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [AW-1:0]     ar_addr, aw_addr;
    logic [IW-1:0]     ar_id, aw_id;
    logic [7:0]        ar_len, aw_len, w_strb;
    logic [2:0]        ar_size, aw_size;
    logic [1:0]        ar_burst, aw_burst, r_resp, b_resp;
    logic [DW-1:0]     r_data, w_data;
    logic              aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;

    int total = 0;
    int bad   = 0;
    logic [63:0] bd [16];

    axi_mport_ctl #(.N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_BEATS(MB), .IDX_W(XW)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .len(len), .strb(strb),
        .commit(commit), .ack(ack), .grant(grant), .done(done), .err(err),
        .buf_wen(buf_wen), .buf_idx(buf_idx), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len),
        .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id), .aw_len(aw_len),
        .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req = '0; we = '0; commit = '0; ack = '0; addr = '0; len = '0; strb = '0;
        buf_wen = 1'b0; buf_idx = '0; buf_wdata = '0;
        ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b0;
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    endtask

    task automatic do_read(input int p, input logic [63:0] a, input int ln, input int nsent,
                           input int badbeat, input logic [1:0] badresp, input bit gaps, input bit exp_err);
        int n, cl, stored;
        cl     = (ln >= MB) ? MB - 1 : ln;
        stored = (nsent < cl + 1) ? nsent : cl + 1;
        we[p] = 1'b0; addr[p*AW +: AW] = a; len[p*8 +: 8] = 8'(ln); req[p] = 1'b1;
        n = 0;
        while (!ar_valid && n < 100) begin tick(); n++; end
        check("ar_valid", 64'(ar_valid), 64'(1));
        check("rd_grant", 64'(grant), 64'(3'b001 << p));
        check("ar_addr", ar_addr, a);
        check("ar_len", 64'(ar_len), 64'(cl));
        check("ar_id", 64'(ar_id), 64'(p));
        check("ar_size", 64'(ar_size), 64'(3));
        check("ar_burst", 64'(ar_burst), 64'(1));
        if (gaps) repeat ($urandom_range(0, 3)) tick();
        ar_ready = 1'b1; tick(); ar_ready = 1'b0;
        check("r_ready", 64'(r_ready), 64'(1));
        check("done_busy", 64'(done), 64'(0));
        for (int k = 0; k < nsent; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            r_valid = 1'b1; r_data = bd[k]; r_last = (k == nsent - 1);
            r_resp = (k == badbeat) ? badresp : 2'b00;
            tick();
            r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00;
        end
        check("rd_done", 64'(done), 64'(3'b001 << p));
        check("rd_err", 64'(err), 64'(exp_err));
        check("r_ready_off", 64'(r_ready), 64'(0));
        req[p] = 1'b0;
        for (int k = 0; k < stored; k++) begin
            buf_idx = XW'(k); #1;
            check("rd_buf", buf_rdata, bd[k]);
        end
        buf_wen = 1'b1; buf_idx = '0; buf_wdata = ~bd[0];
        tick();
        buf_wen = 1'b0; #1;
        check("buf_wen_ignored", buf_rdata, bd[0]);
        check("done_hold", 64'(done), 64'(3'b001 << p));
        ack[p] = 1'b1; tick(); ack[p] = 1'b0;
        check("rd_release", 64'(grant), 64'(0));
        check("rd_done_clr", 64'(done), 64'(0));
    endtask

    task automatic do_write(input int p, input logic [63:0] a, input int ln, input logic [7:0] st,
                            input logic [1:0] br, input bit gaps, input bit exp_err, input int rst_at);
        int n, cl;
        bit rst_hit;
        cl = (ln >= MB) ? MB - 1 : ln;
        rst_hit = 1'b0;
        we[p] = 1'b1; addr[p*AW +: AW] = a; len[p*8 +: 8] = 8'(ln); strb[p*8 +: 8] = st; req[p] = 1'b1;
        n = 0;
        while (grant == '0 && n < 100) begin tick(); n++; end
        check("wr_grant", 64'(grant), 64'(3'b001 << p));
        for (int k = 0; k <= cl; k++) begin
            buf_wen = 1'b1; buf_idx = XW'(k); buf_wdata = bd[k];
            tick();
        end
        buf_wen = 1'b0;
        commit[(p + 1) % NP] = 1'b1; tick(); commit = '0;
        check("foreign_commit", 64'(aw_valid), 64'(0));
        commit[p] = 1'b1; tick(); commit[p] = 1'b0;
        check("aw_valid", 64'(aw_valid), 64'(1));
        check("w_before_aw", 64'(w_valid), 64'(0));
        check("aw_addr", aw_addr, a);
        check("aw_len", 64'(aw_len), 64'(cl));
        check("aw_id", 64'(aw_id), 64'(p));
        check("aw_size", 64'(aw_size), 64'(3));
        check("aw_burst", 64'(aw_burst), 64'(1));
        if (gaps) repeat ($urandom_range(0, 3)) tick();
        aw_ready = 1'b1; tick(); aw_ready = 1'b0;
        for (int k = 0; k <= cl; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            check("w_valid", 64'(w_valid), 64'(1));
            if (k == rst_at) begin
                #1 rst = 1'b0;
                #1;
                check("rst_valids", 64'({ar_valid, aw_valid, w_valid, r_ready, b_ready}), 64'(0));
                check("rst_grant", 64'(grant), 64'(0));
                check("rst_done", 64'({done, err}), 64'(0));
                clear_inputs();
                tick();
                rst = 1'b1;
                tick();
                check("post_rst_idle", 64'({grant, aw_valid, w_valid, ar_valid}), 64'(0));
                rst_hit = 1'b1;
                break;
            end
            check("w_data", w_data, bd[k]);
            check("w_strb", 64'(w_strb), 64'(st));
            check("w_last", 64'(w_last), 64'(k == cl));
            w_ready = 1'b1; tick(); w_ready = 1'b0;
        end
        if (!rst_hit) begin
            check("w_extra", 64'(w_valid), 64'(0));
            check("b_ready", 64'(b_ready), 64'(1));
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            b_valid = 1'b1; b_resp = br; tick(); b_valid = 1'b0;
            check("wr_done", 64'(done), 64'(3'b001 << p));
            check("wr_err", 64'(err), 64'(exp_err));
            req[p] = 1'b0; we[p] = 1'b0;
            ack[p] = 1'b1; tick(); ack[p] = 1'b0;
            check("wr_release", 64'(grant), 64'(0));
        end
    endtask

    typedef struct {
        bit         wr;
        int         p;
        int         ln;
        int         nsent;
        int         badbeat;
        logic [1:0] resp;
        logic [7:0] st;
        bit         exp_err;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{1'b0, 1, 3, 4, 2, 2'b10, 8'h00, 1'b1};
        tbl[1] = '{1'b0, 2, 7, 3, -1, 2'b00, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 0, 12, 8, -1, 2'b00, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 1, 7, 9, -1, 2'b00, 8'h00, 1'b0};
        tbl[4] = '{1'b1, 2, 3, 0, -1, 2'b00, 8'hFF, 1'b0};
        tbl[5] = '{1'b1, 0, 7, 0, -1, 2'b11, 8'hF0, 1'b1};
        tbl[6] = '{1'b0, 0, 0, 1, 0, 2'b11, 8'h00, 1'b1};
        tbl[7] = '{1'b0, 2, 2, 3, 1, 2'b01, 8'h00, 1'b0};

        clear_inputs();
        rst = 1'b0;
        repeat (3) tick();
        check("reset_grant", 64'(grant), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_err", 64'(err), 64'(0));
        check("reset_valids", 64'({ar_valid, aw_valid, w_valid, r_ready, b_ready}), 64'(0));
        rst = 1'b1;
        tick();

        for (int k = 0; k < 16; k++) bd[k] = 64'h11 * 64'(k + 1);
        do_read(0, 64'h8000_0000, 7, 8, -1, 2'b00, 1'b0, 1'b0);
        buf_idx = 3'd3; #1;
        check("plan_buf3", buf_rdata, 64'h44);

        bd[0] = 64'hDEADBEEF_CAFEF00D;
        do_write(1, 64'h9000_0040, 0, 8'h0F, 2'b10, 1'b0, 1'b1, -1);

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 16; k++) bd[k] = {$urandom, $urandom};
            if (tbl[i].wr)
                do_write(tbl[i].p, {32'h0, $urandom}, tbl[i].ln, tbl[i].st, tbl[i].resp, 1'b0, tbl[i].exp_err, -1);
            else
                do_read(tbl[i].p, {32'h0, $urandom}, tbl[i].ln, tbl[i].nsent, tbl[i].badbeat,
                        tbl[i].resp, 1'b0, tbl[i].exp_err);
        end

        for (int t = 0; t < 10; t++) begin
            int p, ln, ns, bb;
            logic [1:0] rs;
            bit ee;
            p  = int'($urandom_range(0, NP - 1));
            ln = int'($urandom_range(0, 7));
            rs = 2'($urandom_range(0, 3));
            for (int k = 0; k < 16; k++) bd[k] = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                ee = rs[1];
                do_write(p, {$urandom, $urandom}, ln, 8'($urandom), rs, 1'b1, ee, -1);
            end else begin
                ns = int'($urandom_range(1, ln + 1));
                bb = int'($urandom_range(0, 8)) - 1;
                ee = (bb >= 0) && (bb < ns) && rs[1];
                do_read(p, {$urandom, $urandom}, ln, ns, bb, rs, 1'b1, ee);
            end
        end

        for (int k = 0; k < 16; k++) bd[k] = {$urandom, $urandom};
        do_write(2, 64'hA000_0000, 7, 8'hFF, 2'b00, 1'b0, 1'b0, 3);

        req = 3'b111; we = '0; len = '0;
        for (int g = 0; g < 5; g++) begin
            int n;
            n = 0;
            while (grant == '0 && n < 100) begin tick(); n++; end
            check("rr_grant", 64'(grant), 64'(3'b001 << (g % 3)));
            check("rr_ar_id", 64'(ar_id), 64'(g % 3));
            ar_ready = 1'b1; tick(); ar_ready = 1'b0;
            r_valid = 1'b1; r_last = 1'b1; r_data = 64'(g); tick();
            r_valid = 1'b0; r_last = 1'b0;
            check("rr_done", 64'(done), 64'(3'b001 << (g % 3)));
            if (g == 0) begin
                repeat (3) tick();
                check("rr_hold_no_ack", 64'(grant), 64'(1));
            end
            ack = grant; tick(); ack = '0;
        end
        req = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_mport_ctl.md
Name: axi_mport_ctl

Overview:
- Parametrised N-port AXI4 master controller; successor of the two-port cache/MMIO bus controller.
- Arbitrates N requesters (I$, D$, MMIO, DMA…) with round-robin fairness and owns a MAX_BEATS-deep line buffer.
- Drives AXI AR/R/AW/W/B directly; no separate rw sub-block.
- New vs. previous generation: configurable port count and line depth, per-request burst length and write strobe, AXI ID = port index, error-response reporting, done/ack handshake per port.

Parameters:
- N_PORTS, 2, number of requesters (2..8)
- ADDR_W, 64, address width
- DATA_W, 64, beat width (power of 2, 32..256)
- ID_W, 4, AXI ID width; must satisfy 2**ID_W >= N_PORTS
- MAX_BEATS, 8, line buffer depth in beats
- IDX_W, $clog2(MAX_BEATS), derived; buffer index width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req  in  N_PORTS  per-port request, level; held until done seen
- we  in  N_PORTS  per-port 1 = write, 0 = read
- addr  in  N_PORTS*ADDR_W  per-port start address (slice p)
- len  in  N_PORTS*8  per-port beats-1; must be < MAX_BEATS
- strb  in  N_PORTS*DATA_W/8  per-port byte strobe, applied to every write beat
- commit  in  N_PORTS  write data loaded into buffer; start write
- ack  in  N_PORTS  consumer done; releases grant
- grant  out  N_PORTS  one-hot current owner
- done  out  N_PORTS  transfer complete; held until ack
- err  out  1  valid with done: any SLVERR/DECERR in the burst
- buf_wen  in  1  granted port writes buffer
- buf_idx  in  IDX_W  buffer beat index (read and write)
- buf_wdata  in  DATA_W  buffer write data
- buf_rdata  out  DATA_W  buffer[buf_idx], combinational
- AXI master channels:
  - ar_valid/ar_ready/ar_addr/ar_id/ar_len/ar_size/ar_burst
  - r_valid/r_ready/r_data/r_resp/r_last
  - aw_valid/aw_ready/aw_addr/aw_id/aw_len/aw_size/aw_burst
  - w_valid/w_ready/w_data/w_strb/w_last
  - b_valid/b_ready/b_resp
  - Standard AXI4 widths per parameters.

Behaviour:
- Reset (rst low, async):
  - state=IDLE; rr pointer=0; grant/done/err=0
  - all *_valid=0, r_ready=0, b_ready=0; buffer contents undefined
- Constant outputs: size=$clog2(DATA_W/8), burst=INCR (2'b01), id=granted port index.
- States: IDLE, LOAD, AR, R, AW, W, B, DONE.
- IDLE:
  - If any req, pick the first set bit searching from rr pointer upward with wrap.
  - Latch addr/len/we/strb of that port, set grant one-hot.
  - Go to AR if read, LOAD if write. Arbitration takes 1 cycle.
- LOAD:
  - Granted port writes beats via buf_wen/buf_idx.
  - On commit[g] go to AW; commit from a non-granted port is ignored.
  - buf_wen is accepted only in LOAD and is ignored elsewhere.
- AR: ar_valid=1 with latched addr and len; on ar_ready go to R. Beat counter=0.
- R:
  - r_ready=1; each r_valid&&r_ready writes r_data to buffer[beat], increments beat, ORs resp[1] into err.
  - On the handshake beat with r_last go to DONE.
  - Beats beyond len+1 are dropped, not written.
  - Early r_last also ends the burst; err is not set for an early r_last.
- AW:
  - aw_valid=1; on aw_ready go to W. AW and W are strictly sequential.
- W:
  - w_valid=1, w_data=buffer[beat], w_strb=latched strb, w_last=(beat==len).
  - Advance beat on w_ready; after the last handshake go to B.
- B: b_ready=1; on b_valid capture b_resp[1] into err and go to DONE.
- DONE:
  - done[g]=1, err stable.
  - On ack[g] clear done/grant/err, set rr pointer = g+1 mod N_PORTS, go to IDLE.
  - Granted port reads the buffer via buf_idx while done is high.
- Deasserting req mid-transfer is ignored; the transaction completes.
- Simultaneous requests: fairness guarantees each requester is served within N_PORTS grants.
- len >= MAX_BEATS: clamp to MAX_BEATS-1.

Decomposition:
- Package axi_mport_pkg holds:
  - state enum
  - AXI_BURST_INCR, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants
  - function rr_pick(req, ptr) returning a one-hot vector
- Natural sub-module: axi_mport_linebuf (MAX_BEATS x DATA_W register array):
  - one write port muxed between AXI R and buf_wen
  - two async read ports: W channel and buf_rdata

Test Plan:
- Single read: port0 req, addr=0x8000_0000, len=7; slave returns beats 0..7 = 0x11..0x88 OKAY.
  - Expect ar_len=7, ar_id=0; done[0] after the r_last handshake.
  - buf_rdata at idx 3 = 0x44; err=0.
- Write with strobe: port1 we, len=0, strb=0x0F, buffer[0]=0xDEADBEEF_CAFEF00D, commit.
  - Expect a single AW then one W with w_last=1, w_strb=0x0F.
  - After b_resp=SLVERR: done[1]=1, err=1.
- Round-robin, N_PORTS=3: all three req held continuously.
  - Grant order 0,1,2,0,1; each grant released only by ack.
- Backpressure: random ar_ready/w_ready/r_valid gaps.
  - No beat lost or duplicated; w_data order matches buffer 0..len.
- Async reset mid-W (beat 3 of 8): within the same cycle all valids=0, grant=0.
  - After release, state is IDLE and a new req is served normally.
- Early r_last at beat 2 of len=7: DONE entered, err=0, beats 0..2 written.
